// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ntt_pkg
//  Description : Shared constants for the NTT datapath blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  // Coefficient width used across the NTT datapath
  localparam int DATA_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/ntt_feeder_if.sv
`default_nettype none
// ============================================================================
//  Interface   : ntt_feeder_if
//  Description : Coefficient input stream (valid/ready) and the pair output
//                towards the NTT core (enable only, no backpressure).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ntt_feeder_if #(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH
) ();

  logic                  coef_valid;
  logic                  coef_ready;
  logic [DATA_WIDTH-1:0] coef_data;
  logic                  ntt_in_en;
  logic [DATA_WIDTH-1:0] ntt_in1;
  logic [DATA_WIDTH-1:0] ntt_in2;
  logic                  poly_done;

  // Environment side: produces coefficients, consumes pairs
  modport master (
    output coef_valid,
    output coef_data,
    input  coef_ready,
    input  ntt_in_en,
    input  ntt_in1,
    input  ntt_in2,
    input  poly_done
  );

  // Feeder side
  modport slave (
    input  coef_valid,
    input  coef_data,
    output coef_ready,
    output ntt_in_en,
    output ntt_in1,
    output ntt_in2,
    output poly_done
  );

endinterface
`default_nettype wire

// File: rtl/ntt_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_feeder
//  Description : Ping-pong buffer between a natural-order coefficient stream
//                and an NTT core. One bank fills while the other drains as
//                pairs (k, k+POLY_N/2), one pair per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_feeder #(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int POLY_N     = 256
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ntt_feeder_if.slave bus
);

  localparam int HALF_N = POLY_N / 2;
  localparam int WR_W   = $clog2(POLY_N);
  localparam int RD_W   = $clog2(HALF_N);

  localparam logic [WR_W-1:0] WR_LAST = WR_W'(POLY_N - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(HALF_N - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  bank_state_t           bank_st     [2];
  bank_state_t           bank_st_nxt [2];
  logic                  wr_bank;
  logic                  wr_bank_nxt;
  logic                  rd_bank;
  logic                  rd_bank_nxt;
  logic [WR_W-1:0]       wr_cnt;
  logic [RD_W-1:0]       rd_cnt;
  logic                  ready_q;
  logic                  ready_nxt;
  logic                  en_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] in1_q;
  logic [DATA_WIDTH-1:0] in2_q;

  logic                  accept;
  logic                  wr_last;
  logic                  drain_busy;
  logic                  drain_last;
  logic                  start_bank;
  logic                  drain_start;
  logic [DATA_WIDTH-1:0] lo_word [2];
  logic [DATA_WIDTH-1:0] hi_word [2];

  // Fills and drains both alternate banks starting from bank 0, so rd_bank
  // always names the oldest filled bank and wr_bank the next one to fill.
  assign accept      = bus.coef_valid && ready_q;
  assign wr_last     = accept && (wr_cnt == WR_LAST);
  assign drain_busy  = (bank_st[rd_bank] == DRAINING);
  assign drain_last  = drain_busy && (rd_cnt == RD_LAST);
  assign start_bank  = drain_last ? ~rd_bank : rd_bank;
  // A drain may start when idle, or chain onto the final pair of the current
  // drain so the output stream has no bubble.
  assign drain_start = (!drain_busy || drain_last) && (bank_st[start_bank] == FULL);

  // Bank storage: written from the fill side, read as a lower/upper half pair
  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [POLY_N];

      // Coefficient write into this bank when it is the fill target
      always_ff @(posedge clk) begin
        if (accept && (wr_bank == 1'(b))) begin
          mem[wr_cnt] <= bus.coef_data;
        end
      end

      assign lo_word[b] = mem[{1'b0, rd_cnt}];
      assign hi_word[b] = mem[{1'b1, rd_cnt}];
    end
  endgenerate

  // Next bank states; fill and drain never act on the same bank in one cycle
  always_comb begin
    bank_st_nxt[0] = bank_st[0];
    bank_st_nxt[1] = bank_st[1];
    wr_bank_nxt    = wr_bank;
    rd_bank_nxt    = rd_bank;
    if (accept) begin
      if (wr_last) begin
        bank_st_nxt[wr_bank] = FULL;
        wr_bank_nxt          = ~wr_bank;
      end else begin
        bank_st_nxt[wr_bank] = FILLING;
      end
    end
    if (drain_last) begin
      bank_st_nxt[rd_bank] = EMPTY;
      rd_bank_nxt          = ~rd_bank;
    end
    if (drain_start) begin
      bank_st_nxt[start_bank] = DRAINING;
    end
    ready_nxt = (bank_st_nxt[wr_bank_nxt] == EMPTY) ||
                (bank_st_nxt[wr_bank_nxt] == FILLING);
  end

  // Bank state machine, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
    end else begin
      bank_st[0] <= bank_st_nxt[0];
      bank_st[1] <= bank_st_nxt[1];
      wr_bank    <= wr_bank_nxt;
      rd_bank    <= rd_bank_nxt;
      ready_q    <= ready_nxt;

      if (accept) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      end

      if (drain_last || drain_start) begin
        rd_cnt <= '0;
      end else if (drain_busy) begin
        rd_cnt <= rd_cnt + 1'b1;
      end

      if (drain_busy) begin
        en_q   <= 1'b1;
        done_q <= drain_last;
        in1_q  <= lo_word[rd_bank];
        in2_q  <= hi_word[rd_bank];
      end else begin
        en_q   <= 1'b0;
        done_q <= 1'b0;
      end
    end
  end

  assign bus.coef_ready = ready_q;
  assign bus.ntt_in_en  = en_q;
  assign bus.poly_done  = done_q;
  assign bus.ntt_in1    = in1_q;
  assign bus.ntt_in2    = in2_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_feeder
//  Description : Self-checking bench for ntt_feeder (POLY_N=256 and POLY_N=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_feeder;

  localparam int DW = ntt_pkg::DATA_WIDTH;
  localparam int N  = 256;
  localparam int H  = N / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ntt_feeder_if #(.DATA_WIDTH(DW)) bif ();
  ntt_feeder_if #(.DATA_WIDTH(DW)) sif ();

  ntt_feeder #(.DATA_WIDTH(DW), .POLY_N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  ntt_feeder #(.DATA_WIDTH(DW), .POLY_N(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model for the 256-point instance -------------
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
  } pair_t;

  logic [DW-1:0] coef_buf [$];
  pair_t         exp_q    [$];

  int   cyc = 0;
  int   en_cycles = 0;
  int   done_cnt = 0;
  int   first_en_cyc = 0;
  int   fill_edge = 0;
  logic prev_en = 1'b0;
  logic [DW-1:0] first_a, first_b, done_a, done_b;

  always @(posedge clk) cyc++;

  // Every accepted coefficient goes into the model; a complete polynomial
  // turns into its expected list of (k, k+N/2) pairs.
  always @(negedge clk) begin
    if (!rst) begin
      prev_en = 1'b0;
    end else begin
      if (bif.coef_valid && bif.coef_ready) begin
        coef_buf.push_back(bif.coef_data);
        if (coef_buf.size() == N) begin
          for (int k = 0; k < H; k++)
            exp_q.push_back({coef_buf[k], coef_buf[k+H], (k == H-1)});
          coef_buf.delete();
          fill_edge = cyc + 1;
        end
      end
      if (bif.ntt_in_en) begin
        pair_t p;
        en_cycles++;
        if (!prev_en) begin
          first_en_cyc = cyc;
          first_a = bif.ntt_in1;
          first_b = bif.ntt_in2;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_pair", 32'(bif.ntt_in1), 32'hFFFF_FFFF);
        end else begin
          p = exp_q.pop_front();
          check("ntt_in1", 32'(bif.ntt_in1), 32'(p.a));
          check("ntt_in2", 32'(bif.ntt_in2), 32'(p.b));
          check("poly_done", 32'(bif.poly_done), 32'(p.last));
        end
        if (bif.poly_done) begin
          done_cnt++;
          done_a = bif.ntt_in1;
          done_b = bif.ntt_in2;
        end
      end else if (bif.poly_done) begin
        check("done_without_en", 32'(bif.poly_done), 0);
      end
      prev_en = bif.ntt_in_en;
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  // gap_mode: 0 = valid every cycle, 1 = alternate valid/idle, 2 = random idles
  task automatic send_poly(input int base, input int gap_mode, input bit rnd);
    for (int i = 0; i < N; i++) begin
      int   guard;
      logic rdy;
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        bif.coef_valid = 1'b0;
        bif.coef_data  = DW'($urandom);
        @(posedge clk); #1;
      end
      bif.coef_valid = 1'b1;
      bif.coef_data  = rnd ? DW'($urandom) : DW'(base + i);
      guard = 0;
      rdy   = bif.coef_ready;
      @(posedge clk); #1;
      while (!rdy && guard < 1000) begin
        rdy = bif.coef_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!rdy) check("accept_timeout", 0, 1);
    end
    bif.coef_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bif.ntt_in_en) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- table for the 4-point instance -------------------------
  typedef struct packed {
    logic [3:0][DW-1:0] c;
    logic [1:0][DW-1:0] e1;
    logic [1:0][DW-1:0] e2;
  } vec_t;

  function automatic vec_t mk(input int c0, c1, c2, c3, a0, b0, a1, b1);
    vec_t v;
    v.c[0] = DW'(c0); v.c[1] = DW'(c1); v.c[2] = DW'(c2); v.c[3] = DW'(c3);
    v.e1[0] = DW'(a0); v.e2[0] = DW'(b0);
    v.e1[1] = DW'(a1); v.e2[1] = DW'(b1);
    return v;
  endfunction

  vec_t          vecs [3];
  logic [DW-1:0] got1 [2];
  logic [DW-1:0] got2 [2];
  logic          gotd [2];
  int            got;
  int            t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(7, 8, 9, 10,        7, 9,      8, 10);
    vecs[1] = mk(0, 1, 2, 3,         0, 2,      1, 3);
    vecs[2] = mk(65535, 0, 4660, 23130, 65535, 4660, 0, 23130);

    bif.coef_valid = 1'b0; bif.coef_data = '0;
    sif.coef_valid = 1'b0; sif.coef_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en",    32'(bif.ntt_in_en),  0);
    check("rst_done",  32'(bif.poly_done),  0);
    check("rst_ready", 32'(bif.coef_ready), 0);
    check("rst_in1",   32'(bif.ntt_in1),    0);
    check("rst_in2",   32'(bif.ntt_in2),    0);
    check("rst_ready_s", 32'(sif.coef_ready), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(bif.coef_ready), 1);

    // 4-point instance: table of polynomials and their expected pairs
    for (int v = 0; v < 3; v++) begin
      check("s_ready", 32'(sif.coef_ready), 1);
      for (int i = 0; i < 4; i++) begin
        sif.coef_valid = 1'b1;
        sif.coef_data  = vecs[v].c[i];
        @(posedge clk); #1;
      end
      sif.coef_valid = 1'b0;
      got = 0;
      for (int w = 0; w < 8 && got < 2; w++) begin
        @(negedge clk);
        if (sif.ntt_in_en) begin
          got1[got] = sif.ntt_in1;
          got2[got] = sif.ntt_in2;
          gotd[got] = sif.poly_done;
          got++;
        end
      end
      check("s_pair_count", 32'(got), 2);
      for (int p = 0; p < 2; p++) begin
        if (p < got) begin
          check("s_in1",  32'(got1[p]), 32'(vecs[v].e1[p]));
          check("s_in2",  32'(got2[p]), 32'(vecs[v].e2[p]));
          check("s_done", 32'(gotd[p]), (p == 1) ? 32'd1 : 32'd0);
        end
      end
      @(negedge clk);
      check("s_en_idle", 32'(sif.ntt_in_en), 0);
    end

    // Single polynomial, values i, valid every cycle
    en_cycles = 0; done_cnt = 0;
    send_poly(0, 0, 1'b0);
    wait_drain();
    check("single_en_cycles", 32'(en_cycles), 128);
    check("single_done_cnt",  32'(done_cnt), 1);
    check("single_latency",   32'(first_en_cyc - fill_edge), 2);
    check("single_first_a",   32'(first_a), 0);
    check("single_first_b",   32'(first_b), 128);
    check("single_last_a",    32'(done_a), 127);
    check("single_last_b",    32'(done_b), 255);

    // Gappy input: valid alternates 1,0,1,0
    en_cycles = 0; done_cnt = 0;
    send_poly(0, 1, 1'b0);
    wait_drain();
    check("gappy_en_cycles", 32'(en_cycles), 128);
    check("gappy_done_cnt",  32'(done_cnt), 1);
    check("gappy_last_b",    32'(done_b), 255);

    // Three polynomials streamed back to back
    en_cycles = 0; done_cnt = 0;
    send_poly(0,    0, 1'b0);
    send_poly(1000, 0, 1'b0);
    send_poly(2000, 0, 1'b0);
    wait_drain();
    check("b2b_en_cycles", 32'(en_cycles), 384);
    check("b2b_done_cnt",  32'(done_cnt), 3);
    check("b2b_last_a",    32'(done_a), 2127);
    check("b2b_last_b",    32'(done_b), 2255);

    // Random data with random idle cycles
    en_cycles = 0; done_cnt = 0;
    for (int r = 0; r < 3; r++) send_poly(0, 2, 1'b1);
    wait_drain();
    check("rand_en_cycles", 32'(en_cycles), 384);
    check("rand_done_cnt",  32'(done_cnt), 3);

    // Reset in the middle of a drain at pair k = 50
    send_poly(0, 0, 1'b0);
    t = 0;
    while (!(bif.ntt_in_en && bif.ntt_in1 == DW'(50)) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reach_k50", 32'(bif.ntt_in1), 50);
    #2 rst = 1'b0;
    #1;
    check("midrst_en",    32'(bif.ntt_in_en),  0);
    check("midrst_done",  32'(bif.poly_done),  0);
    check("midrst_ready", 32'(bif.coef_ready), 0);
    coef_buf.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_after", 32'(bif.coef_ready), 1);
    en_cycles = 0; done_cnt = 0;
    send_poly(3000, 0, 1'b0);
    wait_drain();
    check("post_rst_en_cycles", 32'(en_cycles), 128);
    check("post_rst_done_cnt",  32'(done_cnt), 1);
    check("post_rst_first_a",   32'(first_a), 3000);
    check("post_rst_first_b",   32'(first_b), 3128);
    check("post_rst_last_a",    32'(done_a), 3127);
    check("post_rst_last_b",    32'(done_b), 3255);
    check("post_rst_latency",   32'(first_en_cyc - fill_edge), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
